// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
// Moore-style control sequencer for a multicycle RISC-V datapath that shares
// one ALU and one unified memory port. It decodes the instruction opcode and
// drives the datapath enables, mux selects and the ALUOp code for the ALU
// decoder. Supports R-type, load, store and beq. Stalls on MemReady and
// traps on illegal opcodes or when a memory access waits too long.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   OPCode     opcode field of the instruction register
//   Zero       ALU zero flag (used by beq)
//   MemReady   memory completed the current read/write this cycle
//   PCWrite    PC load enable
//   IRWrite    instruction register / OldPC load enable
//   AdrSrc     memory address select (0 = PC, 1 = ALUOut)
//   MemRead    memory read request
//   MemWrite   memory write request
//   RegWrite   register file write enable
//   ALUSrcA    ALU A select (00 = PC, 01 = OldPC, 10 = rs1)
//   ALUSrcB    ALU B select (00 = rs2, 01 = ImmExt, 10 = constant 4)
//   ALUOp      00 = add, 01 = subtract, 10 = funct-decoded
//   ResultSrc  00 = ALUOut, 01 = memory data, 10 = ALU result
//   Illegal    sticky trap flag
//   State      current state encoding (debug)
module multicycle_control_fsm #(
  parameter int MAX_WAIT = 16,
  parameter int WAIT_W   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] OPCode,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ResultSrc,
  output logic       Illegal,
  output logic [3:0] State
);

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    ALUWB    = 4'd7,
    BEQ      = 4'd8,
    TRAP     = 4'd9
  } state_t;

  // Registered per-state control word. The two qualifier flags mark the
  // states whose PC/IR writes depend on a live input (MemReady or Zero).
  typedef struct packed {
    logic       write_on_ready;
    logic       pc_on_zero;
    logic       adr_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       illegal;
  } ctrl_t;

  state_t            state;
  state_t            state_next;
  logic [WAIT_W-1:0] wait_cnt;
  ctrl_t             ctrl;
  logic              in_wait;
  logic              timed_out;

  // Only FETCH, MEMREAD and MEMWRITE wait on memory; the timeout is armed
  // when the counter reaches its last allowed value with memory still busy.
  assign in_wait   = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
  assign timed_out = (MAX_WAIT != 0) && !MemReady &&
                     (wait_cnt == WAIT_W'(MAX_WAIT - 1));

  function automatic state_t next_of(state_t s, logic [6:0] opc, logic ready,
                                     logic tmo);
    state_t n;
    case (s)
      FETCH:    n = ready ? DECODE : (tmo ? TRAP : FETCH);
      DECODE: begin
        if (opc == OP_LOAD || opc == OP_STORE) n = MEMADR;
        else if (opc == OP_RTYPE)              n = EXECUTER;
        else if (opc == OP_BEQ)                n = BEQ;
        else                                   n = TRAP;
      end
      MEMADR: begin
        if (opc == OP_LOAD)       n = MEMREAD;
        else if (opc == OP_STORE) n = MEMWRITE;
        else                      n = TRAP;
      end
      MEMREAD:  n = ready ? MEMWB : (tmo ? TRAP : MEMREAD);
      MEMWB:    n = FETCH;
      MEMWRITE: n = ready ? FETCH : (tmo ? TRAP : MEMWRITE);
      EXECUTER: n = ALUWB;
      ALUWB:    n = FETCH;
      BEQ:      n = FETCH;
      TRAP:     n = TRAP;
      default:  n = TRAP;
    endcase
    return n;
  endfunction

  function automatic ctrl_t decode(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.write_on_ready = 1'b1;
        c.mem_read       = 1'b1;
        c.alu_src_b      = 2'b10;
        c.result_src     = 2'b10;
      end
      DECODE: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
      end
      MEMADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      MEMREAD: begin
        c.adr_src  = 1'b1;
        c.mem_read = 1'b1;
      end
      MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
      end
      MEMWRITE: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      EXECUTER: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b10;
      end
      ALUWB:    c.reg_write = 1'b1;
      BEQ: begin
        c.pc_on_zero = 1'b1;
        c.alu_src_a  = 2'b10;
        c.alu_op     = 2'b01;
      end
      TRAP:     c.illegal = 1'b1;
      default:  c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  assign state_next = next_of(state, OPCode, MemReady, timed_out);

  // State, wait counter and the control word decoded from the state being
  // entered, so every select comes straight from a flop. The counter runs
  // only while a memory state stays put waiting; any transition or a ready
  // cycle clears it, which also covers clearing on entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      wait_cnt <= '0;
      ctrl     <= decode(FETCH);
    end else begin
      state <= state_next;
      ctrl  <= decode(state_next);
      if (in_wait && !MemReady && (state_next == state))
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
    end
  end

  // Enables are blanked while reset is held so an interrupted instruction
  // cannot write anything before the reset edge lands.
  assign IRWrite   = !reset && ctrl.write_on_ready && MemReady;
  assign PCWrite   = !reset && ((ctrl.write_on_ready && MemReady) ||
                                (ctrl.pc_on_zero && Zero));
  assign MemRead   = !reset && ctrl.mem_read;
  assign MemWrite  = !reset && ctrl.mem_write;
  assign RegWrite  = !reset && ctrl.reg_write;
  assign AdrSrc    = ctrl.adr_src;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ALUOp     = ctrl.alu_op;
  assign ResultSrc = ctrl.result_src;
  assign Illegal   = ctrl.illegal;
  assign State     = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm
// Instruction-level reference model: each instruction is expanded into its
// cycle-by-cycle timeline from opcode class and memory wait counts, the
// expected outputs are queued as inputs are driven, and a negedge monitor
// pops and compares them against the DUT.
module tb_multicycle_control_fsm;

  localparam int MAXW = 4;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BQ = 7'b1100011;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, adr, mrd, mwr, rgw;
    logic [1:0] sa, sb, op, res;
    logic       ill;
  } exp_t;

  typedef struct {
    logic       rst;
    logic [6:0] opc;
    logic       rdy;
    logic       zero;
    exp_t       e;
  } cyc_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] OPCode = 7'd0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;
  logic       PCWrite, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite, Illegal;
  logic [1:0] ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
  logic [3:0] State;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  cyc_t plan[$];
  logic [6:0] cur_op;

  multicycle_control_fsm #(.MAX_WAIT(MAXW), .WAIT_W(8)) dut (
    .clk(clk), .reset(reset), .OPCode(OPCode), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ResultSrc(ResultSrc),
    .Illegal(Illegal), .State(State)
  );

  always #5 clk = ~clk;

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  // Static outputs of each state, straight from the state descriptions.
  function automatic exp_t static_exp(int s);
    exp_t e;
    e = '0;
    e.st = 4'(s);
    case (s)
      0: begin e.mrd = 1; e.sb = 2'b10; e.res = 2'b10; end
      1: begin e.sa = 2'b01; e.sb = 2'b01; end
      2: begin e.sa = 2'b10; e.sb = 2'b01; end
      3: begin e.adr = 1; e.mrd = 1; end
      4: begin e.res = 2'b01; e.rgw = 1; end
      5: begin e.adr = 1; e.mwr = 1; end
      6: begin e.sa = 2'b10; e.op = 2'b10; end
      7: e.rgw = 1;
      8: begin e.sa = 2'b10; e.op = 2'b01; end
      9: e.ill = 1;
      default: ;
    endcase
    return e;
  endfunction

  task automatic add_cycle(int s, logic rdy, logic zero, logic pcw, logic irw);
    cyc_t c;
    c.rst = 1'b0; c.opc = cur_op; c.rdy = rdy; c.zero = zero;
    c.e = static_exp(s);
    c.e.pcw = pcw;
    c.e.irw = irw;
    plan.push_back(c);
  endtask

  task automatic add_reset(int s);
    cyc_t c;
    c.rst = 1'b1; c.opc = cur_op; c.rdy = rb(); c.zero = rb();
    c.e = static_exp(s);
    c.e.mrd = 0; c.e.mwr = 0; c.e.rgw = 0;
    plan.push_back(c);
  endtask

  // A memory phase: waits cycles busy, then one ready cycle, unless the
  // wait reaches the timeout limit, in which case it traps.
  task automatic mem_phase(int s, int waits, output bit trapped);
    trapped = 0;
    if (waits >= MAXW) begin
      repeat (MAXW) add_cycle(s, 1'b0, rb(), 1'b0, 1'b0);
      trapped = 1;
    end else begin
      repeat (waits) add_cycle(s, 1'b0, rb(), 1'b0, 1'b0);
      add_cycle(s, 1'b1, rb(), 1'b0, 1'b0);
    end
  endtask

  task automatic build(logic [6:0] op, int fw, int mw, logic z, int hold);
    bit trapped;
    logic rdy;
    plan.delete();
    cur_op = op;
    trapped = 0;
    if (fw >= MAXW) begin
      repeat (MAXW) add_cycle(0, 1'b0, rb(), 1'b0, 1'b0);
      trapped = 1;
    end else begin
      repeat (fw) add_cycle(0, 1'b0, rb(), 1'b0, 1'b0);
      add_cycle(0, 1'b1, rb(), 1'b1, 1'b1);
    end
    if (!trapped) begin
      add_cycle(1, rb(), rb(), 1'b0, 1'b0);
      case (op)
        OP_R: begin
          add_cycle(6, rb(), rb(), 1'b0, 1'b0);
          add_cycle(7, rb(), rb(), 1'b0, 1'b0);
        end
        OP_LD: begin
          add_cycle(2, rb(), rb(), 1'b0, 1'b0);
          mem_phase(3, mw, trapped);
          if (!trapped) add_cycle(4, rb(), rb(), 1'b0, 1'b0);
        end
        OP_ST: begin
          add_cycle(2, rb(), rb(), 1'b0, 1'b0);
          mem_phase(5, mw, trapped);
        end
        OP_BQ: begin
          rdy = rb();
          add_cycle(8, rdy, z, z, 1'b0);
        end
        default: trapped = 1;
      endcase
    end
    if (trapped) begin
      repeat (hold) add_cycle(9, rb(), rb(), 1'b0, 1'b0);
      add_reset(9);
    end
  endtask

  // Abandon the instruction at cycle idx with a two-cycle reset: the first
  // cycle still shows the interrupted state, the second shows FETCH.
  task automatic inject_reset(int idx);
    int s;
    s = int'(plan[idx].e.st);
    while (plan.size() > idx) void'(plan.pop_back());
    add_reset(s);
    add_reset(0);
  endtask

  task automatic applyStimulus();
    foreach (plan[i]) begin
      @(posedge clk);
      #1;
      reset    = plan[i].rst;
      OPCode   = plan[i].opc;
      MemReady = plan[i].rdy;
      Zero     = plan[i].zero;
      exp_q.push_back(plan[i].e);
    end
  endtask

  task automatic run_instr(logic [6:0] op, int fw, int mw, logic z, int hold,
                           int rst_at);
    build(op, fw, mw, z, hold);
    if (rst_at >= 0 && rst_at < plan.size()) inject_reset(rst_at);
    applyStimulus();
  endtask

  task automatic checkOutput(exp_t e);
    exp_t got;
    got = {State, PCWrite, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, ResultSrc, Illegal};
    tests++;
    if (got !== e) begin
      fails++;
      $display("[TB] FAIL outputs t=%0t: got st=%0d pcw=%b irw=%b adr=%b mrd=%b mwr=%b rgw=%b sa=%b sb=%b op=%b res=%b ill=%b, expected st=%0d pcw=%b irw=%b adr=%b mrd=%b mwr=%b rgw=%b sa=%b sb=%b op=%b res=%b ill=%b",
               $time, got.st, got.pcw, got.irw, got.adr, got.mrd, got.mwr,
               got.rgw, got.sa, got.sb, got.op, got.res, got.ill,
               e.st, e.pcw, e.irw, e.adr, e.mrd, e.mwr, e.rgw, e.sa, e.sb,
               e.op, e.res, e.ill);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
  end

  initial begin
    logic [6:0] op;
    int r, fw, mw, guard;
    cur_op = 7'd0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    begin
      exp_t e;
      e = static_exp(0);
      e.mrd = 0;
      exp_q.push_back(e);
    end

    // Directed cases
    run_instr(OP_R, 0, 0, 1'b0, 1, -1);
    run_instr(OP_LD, 0, 3, 1'b0, 1, -1);
    run_instr(OP_BQ, 0, 0, 1'b1, 1, -1);
    run_instr(OP_BQ, 0, 0, 1'b0, 1, -1);
    run_instr(7'b1111111, 0, 0, 1'b0, 20, -1);
    run_instr(OP_R, 4, 0, 1'b0, 3, -1);
    run_instr(OP_R, 3, 0, 1'b0, 1, -1);
    run_instr(OP_ST, 0, 2, 1'b0, 1, 3);
    run_instr(OP_ST, 1, 1, 1'b0, 1, -1);
    run_instr(OP_LD, 0, 4, 1'b0, 2, -1);

    // Randomised instruction stream
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 2)      op = OP_R;
      else if (r <= 4) op = OP_LD;
      else if (r <= 6) op = OP_ST;
      else if (r <= 8) op = OP_BQ;
      else begin
        op = 7'($urandom);
        if (op == OP_R || op == OP_LD || op == OP_ST || op == OP_BQ)
          op = 7'b1111111;
      end
      fw = ($urandom_range(0, 9) == 0) ? $urandom_range(MAXW, MAXW + 2)
                                       : $urandom_range(0, 2);
      mw = ($urandom_range(0, 9) == 0) ? $urandom_range(MAXW, MAXW + 2)
                                       : $urandom_range(0, 3);
      run_instr(op, fw, mw, rb(), $urandom_range(1, 4),
                ($urandom_range(0, 9) == 0) ? $urandom_range(0, 8) : -1);
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (exp_q.size() > 0) begin
      fails++;
      $display("[TB] FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
